// File: rtl/dma_mon_pkg.sv
// Shared types and rule numbering for the 8237A-5 DMA bus monitor.
package dma_mon_pkg;

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_ACK1, M_XFER} m_state_t;

  localparam int NUM_RULES          = 8;
  localparam int RULE_HLDA_TIMEOUT  = 0;
  localparam int RULE_AEN_MISSING   = 1;
  localparam int RULE_ADSTB_MISSING = 2;
  localparam int RULE_ADSTB_WIDTH   = 3;
  localparam int RULE_STROBE_OVERLAP = 4;
  localparam int RULE_STROBE_WIDTH  = 5;
  localparam int RULE_EOP_CONFLICT  = 6;
  localparam int RULE_DACK_ILLEGAL  = 7;

  function automatic logic [2:0] lowest_rule(input logic [NUM_RULES-1:0] v);
    lowest_rule = 3'd0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (v[i]) lowest_rule = 3'(i);
    end
  endfunction

endpackage

// File: rtl/dma_mon_capture.sv
// Error bookkeeping: sticky bits, saturating violation-cycle count, first-error capture.
// One cycle from violation to visible status; observe-only, no backpressure.
module dma_mon_capture
  import dma_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [NUM_RULES-1:0] viol,
  input  logic [TS_W-1:0]      ts,
  output logic [NUM_RULES-1:0] err_pulse,
  output logic [NUM_RULES-1:0] err_sticky,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [2:0]           first_err_id,
  output logic [TS_W-1:0]      first_err_ts,
  output logic                 first_err_vld
);

  logic any_viol;
  assign any_viol = |viol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse     <= '0;
      err_sticky    <= '0;
      err_cnt       <= '0;
      first_err_id  <= '0;
      first_err_ts  <= '0;
      first_err_vld <= 1'b0;
    end else begin
      err_pulse  <= viol;
      err_sticky <= (clr ? '0 : err_sticky) | viol;

      // clr wins over old state, but a violation in the same cycle is still recorded
      if (clr)
        err_cnt <= {{(CNT_W-1){1'b0}}, any_viol};
      else if (any_viol && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;

      if (any_viol && (clr || !first_err_vld)) begin
        first_err_id  <= lowest_rule(viol);
        first_err_ts  <= ts;
        first_err_vld <= 1'b1;
      end else if (clr) begin
        first_err_id  <= '0;
        first_err_ts  <= '0;
        first_err_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_bus_monitor.sv
// Passive 8237A-5 bus protocol checker with per-channel transfer counts.
// Status appears one cycle after the offending bus cycle; never drives the bus, no backpressure.
module dma_bus_monitor
  import dma_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int TS_W         = 16,
  parameter int HLDA_TIMEOUT = 16,
  parameter int WAIT_MAX     = 8
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    CS_N,
  input  logic                    HRQ,
  input  logic                    HLDA,
  input  logic                    AEN,
  input  logic                    ADSTB,
  input  logic                    READY,
  input  logic                    IOR_N,
  input  logic                    IOW_N,
  input  logic                    EOP_N,
  input  logic [NUM_CH-1:0]       DACK,
  input  logic [7:0]              err_en,
  input  logic                    clr,
  output logic [7:0]              err_pulse,
  output logic [7:0]              err_sticky,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [2:0]              first_err_id,
  output logic [TS_W-1:0]         first_err_ts,
  output logic                    first_err_vld,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt,
  output logic                    irq
);

  localparam int TO_W = $clog2(HLDA_TIMEOUT + 2);
  localparam int WT_W = $clog2(WAIT_MAX + 1);

  m_state_t         state, state_nxt;
  logic             in_req, in_ack1, in_xfer;
  logic             hlda_q, adstb_q, ior_q, iow_q, ready_q;
  logic [TO_W-1:0]  to_cnt;
  logic [WT_W-1:0]  wait_cnt;
  logic [TS_W-1:0]  ts;
  logic             hlda_rise, strobe, wait_step, wait_over, xfer_done;
  logic [NUM_RULES-1:0] raw, viol;

  assign hlda_rise = HLDA && !hlda_q;
  assign strobe    = !IOR_N || !IOW_N;
  assign wait_step = strobe && !READY;
  assign wait_over = wait_step && (wait_cnt == WT_W'(WAIT_MAX));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= M_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!CS_N) begin
      state_nxt = M_IDLE;
    end else begin
      case (state)
        M_IDLE:  if (hlda_rise) state_nxt = M_ACK1;
                 else if (HRQ && !HLDA) state_nxt = M_REQ;
        M_REQ:   if (hlda_rise) state_nxt = M_ACK1;
                 else if (!HRQ) state_nxt = M_IDLE;
        M_ACK1:  state_nxt = M_XFER;
        M_XFER:  if (!HLDA) state_nxt = M_IDLE;
        default: state_nxt = M_IDLE;
      endcase
    end
  end

  always_comb begin
    in_req  = 1'b0;
    in_ack1 = 1'b0;
    in_xfer = 1'b0;
    if (CS_N) begin
      case (state)
        M_REQ:   in_req  = 1'b1;
        M_ACK1:  in_ack1 = 1'b1;
        M_XFER:  in_xfer = 1'b1;
        default: ;
      endcase
    end
  end

  // to_cnt stops one past the limit so the timeout fires exactly once per request
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      to_cnt   <= '0;
      wait_cnt <= '0;
      ts       <= '0;
      hlda_q   <= 1'b0;
      adstb_q  <= 1'b0;
      ior_q    <= 1'b1;
      iow_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      if (!in_req)                               to_cnt <= '0;
      else if (to_cnt <= TO_W'(HLDA_TIMEOUT))    to_cnt <= to_cnt + 1'b1;
      if (!wait_step)                            wait_cnt <= '0;
      else if (wait_cnt != WT_W'(WAIT_MAX))      wait_cnt <= wait_cnt + 1'b1;
      ts      <= ts + 1'b1;
      hlda_q  <= HLDA;
      adstb_q <= ADSTB;
      ior_q   <= IOR_N;
      iow_q   <= IOW_N;
      ready_q <= READY;
    end
  end

  always_comb begin
    raw = '0;
    raw[RULE_HLDA_TIMEOUT]   = in_req && (to_cnt == TO_W'(HLDA_TIMEOUT));
    raw[RULE_AEN_MISSING]    = in_ack1 && !AEN;
    raw[RULE_ADSTB_MISSING]  = in_ack1 && !ADSTB;
    raw[RULE_ADSTB_WIDTH]    = CS_N && ADSTB && adstb_q;
    raw[RULE_STROBE_OVERLAP] = !IOR_N && !IOW_N;
    raw[RULE_STROBE_WIDTH]   = CS_N && ((!IOR_N && !ior_q && ready_q) ||
                                        (!IOW_N && !iow_q && ready_q) || wait_over);
    raw[RULE_EOP_CONFLICT]   = CS_N && !EOP_N && (AEN || ADSTB || strobe);
    raw[RULE_DACK_ILLEGAL]   = !$onehot0(DACK) || ((|DACK) && !HLDA);
  end

  assign viol      = raw & err_en;
  assign xfer_done = in_xfer && ((IOR_N && !ior_q) || (IOW_N && !iow_q)) && $onehot(DACK);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
        cnt_q <= '0;
      else if (clr)
        cnt_q <= {{(CNT_W-1){1'b0}}, xfer_done && DACK[g]};
      else if (xfer_done && DACK[g] && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
    assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end

  dma_mon_capture #(.CNT_W(CNT_W), .TS_W(TS_W)) u_capture (
    .clk           (CLOCK),
    .rst           (RESET),
    .clr           (clr),
    .viol          (viol),
    .ts            (ts),
    .err_pulse     (err_pulse),
    .err_sticky    (err_sticky),
    .err_cnt       (err_cnt),
    .first_err_id  (first_err_id),
    .first_err_ts  (first_err_ts),
    .first_err_vld (first_err_vld)
  );

  assign irq = |err_sticky;

endmodule

// File: tb/tb_dma_bus_monitor.sv
// Directed scenarios plus biased random bus traffic, scored against a cycle-level rule model.
module tb_dma_bus_monitor;
  import dma_mon_pkg::*;

  localparam int NUM_CH = 4, CNT_W = 8, TS_W = 16, HLDA_TIMEOUT = 16, WAIT_MAX = 8;
  localparam int SAT = (1 << CNT_W) - 1;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_GNT = 2, PH_XFER = 3;

  logic CLOCK = 1'b0, RESET = 1'b1;
  logic CS_N, HRQ, HLDA, AEN, ADSTB, READY, IOR_N, IOW_N, EOP_N, clr;
  logic [NUM_CH-1:0] DACK;
  logic [7:0] err_en;
  logic [7:0] err_pulse, err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0] first_err_id;
  logic [TS_W-1:0] first_err_ts;
  logic first_err_vld, irq;
  logic [NUM_CH*CNT_W-1:0] xfer_cnt;

  always #5 CLOCK = ~CLOCK;

  dma_bus_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W),
                    .HLDA_TIMEOUT(HLDA_TIMEOUT), .WAIT_MAX(WAIT_MAX)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CS_N(CS_N), .HRQ(HRQ), .HLDA(HLDA), .AEN(AEN),
    .ADSTB(ADSTB), .READY(READY), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .DACK(DACK), .err_en(err_en), .clr(clr), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .first_err_id(first_err_id),
    .first_err_ts(first_err_ts), .first_err_vld(first_err_vld),
    .xfer_cnt(xfer_cnt), .irq(irq)
  );

  int n_vec = 0, n_mis = 0;

  // bus-level model state
  int ph, req_seen, wait_run, m_ts;
  bit p_hlda, p_adstb, p_ior_low, p_iow_low, p_ready;
  logic [7:0] e_pulse, e_sticky;
  int e_cnt, e_id, e_ts, e_xfer[NUM_CH];
  bit e_vld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; req_seen = 0; wait_run = 0; m_ts = 0;
    p_hlda = 0; p_adstb = 0; p_ior_low = 0; p_iow_low = 0; p_ready = 0;
    e_pulse = '0; e_sticky = '0; e_cnt = 0; e_id = 0; e_ts = 0; e_vld = 0;
    for (int i = 0; i < NUM_CH; i++) e_xfer[i] = 0;
  endtask

  task automatic bus_idle();
    CS_N = 1; HRQ = 0; HLDA = 0; AEN = 0; ADSTB = 0; READY = 1;
    IOR_N = 1; IOW_N = 1; EOP_N = 1; DACK = '0; clr = 0;
  endtask

  task automatic check_outputs();
    logic [NUM_CH*CNT_W-1:0] ex;
    for (int i = 0; i < NUM_CH; i++) ex[i*CNT_W +: CNT_W] = CNT_W'(e_xfer[i]);
    check("err_pulse", 64'(err_pulse), 64'(e_pulse));
    check("err_sticky", 64'(err_sticky), 64'(e_sticky));
    check("err_cnt", 64'(err_cnt), 64'(e_cnt));
    check("first_err_vld", 64'(first_err_vld), 64'(e_vld));
    check("first_err_id", 64'(first_err_id), 64'(e_id));
    check("first_err_ts", 64'(first_err_ts), 64'(e_ts));
    check("xfer_cnt", 64'(xfer_cnt), 64'(ex));
    check("irq", 64'(irq), 64'(e_sticky != 0));
  endtask

  // Evaluate the bus rules on the current inputs, advance one edge, compare.
  task automatic tick();
    logic [7:0] raw, viol;
    bit master, ior_low, iow_low, strobe, hr, rise;
    int run, nph;
    master = CS_N; ior_low = !IOR_N; iow_low = !IOW_N;
    strobe = ior_low || iow_low; hr = HLDA && !p_hlda;
    run = (strobe && !READY) ? wait_run + 1 : 0;
    raw = '0;
    raw[0] = master && ph == PH_REQ && req_seen == HLDA_TIMEOUT;
    raw[1] = master && ph == PH_GNT && !AEN;
    raw[2] = master && ph == PH_GNT && !ADSTB;
    raw[3] = master && ADSTB && p_adstb;
    raw[4] = ior_low && iow_low;
    raw[5] = master && ((ior_low && p_ior_low && p_ready) || (iow_low && p_iow_low && p_ready) || run > WAIT_MAX);
    raw[6] = master && !EOP_N && (AEN || ADSTB || strobe);
    raw[7] = ($countones(DACK) > 1) || (DACK != 0 && !HLDA);
    viol = raw & err_en;

    if (clr) begin
      e_sticky = '0; e_cnt = 0; e_vld = 0; e_id = 0; e_ts = 0;
      for (int i = 0; i < NUM_CH; i++) e_xfer[i] = 0;
    end
    e_pulse = viol;
    e_sticky |= viol;
    if (viol != 0) begin
      if (e_cnt < SAT) e_cnt++;
      if (!e_vld) begin
        e_vld = 1; e_ts = m_ts;
        for (int b = 7; b >= 0; b--) if (viol[b]) e_id = b;
      end
    end
    rise = (!ior_low && p_ior_low) || (!iow_low && p_iow_low);
    if (master && ph == PH_XFER && rise && $countones(DACK) == 1)
      for (int i = 0; i < NUM_CH; i++) if (DACK[i] && e_xfer[i] < SAT) e_xfer[i]++;

    case (ph)
      PH_IDLE: nph = hr ? PH_GNT : (HRQ && !HLDA) ? PH_REQ : PH_IDLE;
      PH_REQ:  nph = hr ? PH_GNT : !HRQ ? PH_IDLE : PH_REQ;
      PH_GNT:  nph = PH_XFER;
      default: nph = HLDA ? PH_XFER : PH_IDLE;
    endcase
    if (!master) nph = PH_IDLE;
    req_seen = (master && ph == PH_REQ) ? req_seen + 1 : 0;
    ph = nph; wait_run = run;
    p_hlda = HLDA; p_adstb = ADSTB; p_ior_low = ior_low; p_iow_low = iow_low; p_ready = READY;
    m_ts = (m_ts + 1) % (1 << TS_W);

    @(posedge CLOCK); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2 RESET = 1;
    #2 RESET = 0;
    model_reset();
    bus_idle();
  endtask

  task automatic start_cycle();
    CS_N = 1; HRQ = 1; tick(); tick();
    HLDA = 1; DACK = 4'b0010; tick();
    AEN = 1; ADSTB = 1; tick();
    ADSTB = 0; IOR_N = 0; tick();
  endtask

  int pulses;

  initial begin
    bus_idle();
    err_en = 8'hFF;
    RESET = 1;
    #22;
    check("rst_pulse", 64'(err_pulse), 64'd0);
    check("rst_sticky", 64'(err_sticky), 64'd0);
    check("rst_cnt", 64'(err_cnt), 64'd0);
    check("rst_vld", 64'(first_err_vld), 64'd0);
    check("rst_xfer", 64'(xfer_cnt), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    RESET = 0;
    model_reset();

    // legal master cycle
    start_cycle();
    IOR_N = 1; IOW_N = 0; tick();
    IOW_N = 1; tick();
    HRQ = 0; HLDA = 0; DACK = '0; AEN = 0; tick();
    check("legal_sticky", 64'(err_sticky), 64'd0);
    check("legal_xfer1", 64'(xfer_cnt[1*CNT_W +: CNT_W]), 64'd2);
    check("legal_irq", 64'(irq), 64'd0);

    // HLDA timeout
    do_reset();
    pulses = 0;
    HRQ = 1;
    repeat (20) begin tick(); if (err_pulse[0]) pulses++; end
    HRQ = 0; tick();
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_id", 64'(first_err_id), 64'd0);
    check("timeout_cnt", 64'(err_cnt), 64'd1);

    // simultaneous violations
    do_reset();
    ADSTB = 1; tick();
    IOR_N = 0; IOW_N = 0; tick();
    check("simul_pulse", 64'(err_pulse), 64'h18);
    bus_idle(); tick();
    check("simul_id", 64'(first_err_id), 64'd3);
    check("simul_cnt", 64'(err_cnt), 64'd1);

    // wait states at and beyond the limit
    do_reset();
    IOR_N = 0; READY = 0; repeat (8) tick();
    IOR_N = 1; READY = 1; tick();
    check("wait8_sticky", 64'(err_sticky), 64'd0);
    IOR_N = 0; READY = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) check("wait9_before", 64'(err_pulse[5]), 64'd0);
      if (k == 9) check("wait9_fire", 64'(err_pulse[5]), 64'd1);
    end
    bus_idle(); tick();

    // slave mode and DACK legality
    do_reset();
    CS_N = 0; ADSTB = 1; repeat (3) tick();
    ADSTB = 0; tick();
    check("slave_adstb", 64'(err_sticky), 64'd0);
    IOR_N = 0; IOW_N = 0; tick();
    check("slave_overlap", 64'(err_pulse), 64'h10);
    IOR_N = 1; IOW_N = 1; DACK = 4'b0011; tick();
    check("dack_illegal", 64'(err_pulse), 64'h80);
    bus_idle(); tick();

    // clear coinciding with a new violation
    clr = 1; EOP_N = 0; AEN = 1; tick();
    check("clr_sticky", 64'(err_sticky), 64'h40);
    check("clr_cnt", 64'(err_cnt), 64'd1);
    check("clr_id", 64'(first_err_id), 64'd6);
    bus_idle(); tick();

    // reset in the middle of a transfer
    start_cycle();
    IOR_N = 1; tick();
    #2 RESET = 1;
    #1;
    check("mid_rst_pulse", 64'(err_pulse), 64'd0);
    check("mid_rst_sticky", 64'(err_sticky), 64'd0);
    check("mid_rst_xfer", 64'(xfer_cnt), 64'd0);
    check("mid_rst_vld", 64'(first_err_vld), 64'd0);
    check("mid_rst_fsm", 64'(dut.state), 64'(M_IDLE));
    #1 RESET = 0;
    model_reset();
    bus_idle();
    repeat (3) tick();

    // biased random traffic
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 250 == 0) err_en = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom);
      if ($urandom_range(31) == 0) CS_N = ~CS_N;
      if ($urandom_range(15) == 0) HRQ = ~HRQ;
      if ($urandom_range(11) == 0) HLDA = ~HLDA;
      AEN = 1'($urandom_range(1));
      ADSTB = ($urandom_range(3) == 0);
      EOP_N = ($urandom_range(15) != 0);
      if ((cyc / 100) % 3 == 2) begin
        READY = ($urandom_range(15) == 0);
        IOR_N = ($urandom_range(7) != 0) ? 1'b0 : 1'b1;
        IOW_N = 1;
      end else begin
        READY = ($urandom_range(3) != 0);
        IOR_N = ($urandom_range(3) != 0);
        IOW_N = ($urandom_range(3) != 0);
      end
      case ($urandom_range(7))
        0:       DACK = 4'($urandom_range(15));
        1, 2, 3: DACK = 4'(1 << $urandom_range(3));
        default: DACK = '0;
      endcase
      clr = ($urandom_range(199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dma_bus_monitor.md
Name: dma_bus_monitor

Overview:
- Synthesizable, parametrised protocol monitor for the 8237A-5 DMA system bus.
- Carries the system-level bus rules into RTL so violations are visible in emulation and silicon debug, not only in simulation.
- Tracks master cycles with a small FSM, flags rule violations, and keeps sticky error status, first-error capture and per-channel transfer counts.
- Sits beside the DMA controller on the external bus; observe-only, never drives the bus.

Parameters:
- NUM_CH, 4: number of DREQ/DACK channels.
- CNT_W, 8: width of the per-channel transfer counters and the error counter; all saturate.
- TS_W, 16: width of the free-running timestamp.
- HLDA_TIMEOUT, 16: maximum number of cycles HRQ may stay high without HLDA.
- WAIT_MAX, 8: maximum consecutive READY-low cycles a strobe may be stretched.

Ports:
- CLOCK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CS_N  in  1  chip select; 1 = master rules active, 0 = slave rules active.
- HRQ, HLDA, AEN, ADSTB, READY  in  1 each  bus controls.
- IOR_N, IOW_N, EOP_N  in  1 each  active-low strobes.
- DACK  in  NUM_CH  DMA acknowledges, active high.
- err_en  in  8  per-rule enable mask.
- clr  in  1  synchronous clear of sticky bits, counters and capture registers.
- err_pulse  out  8  one-cycle flag per rule violated.
- err_sticky  out  8  accumulated violations.
- err_cnt  out  CNT_W  total violation cycles, saturating.
- first_err_id  out  3  lowest-numbered rule of the first violation.
- first_err_ts  out  TS_W  timestamp of the first violation.
- first_err_vld  out  1  capture registers are valid.
- xfer_cnt  out  NUM_CH*CNT_W  completed transfers per channel; channel i occupies bits [i*CNT_W +: CNT_W].
- irq  out  1  OR of err_sticky.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in M_IDLE.
  - Timestamp, wait counter and timeout counter are 0.
  - One-cycle history registers reset to the idle bus value: HLDA=0, ADSTB=0, IOR_N=1, IOW_N=1.
- Timing: inputs are sampled each rising edge. A violation in cycle t produces err_pulse, err_sticky, err_cnt and capture updates at edge t+1, i.e. one cycle of latency.
- Master FSM (runs only while CS_N=1; CS_N=0 forces M_IDLE):
  - M_IDLE -> M_REQ when HRQ=1 and HLDA=0.
  - M_IDLE or M_REQ -> M_ACK1 on an HLDA rise, detected as the previous HLDA was 0 and the current HLDA is 1.
  - M_REQ -> M_IDLE when HRQ falls.
  - M_ACK1 -> M_XFER unconditionally.
  - M_XFER -> M_IDLE when HLDA=0.
- Rules (bit index = rule id; a bit is reported only when its err_en bit is 1):
  - 0 HLDA_TIMEOUT: in M_REQ, timeout counter exceeds HLDA_TIMEOUT. Fires once, then the counter holds until the FSM leaves M_REQ.
  - 1 AEN_MISSING: in M_ACK1 with AEN=0.
  - 2 ADSTB_MISSING: in M_ACK1 with ADSTB=0.
  - 3 ADSTB_WIDTH: master, ADSTB=1 for two consecutive cycles.
  - 4 STROBE_OVERLAP: IOR_N=0 and IOW_N=0 in the same cycle. Checked in both modes.
  - 5 STROBE_WIDTH: master, strobe stays low a second cycle while READY=1 in the first, or READY=0 for more than WAIT_MAX consecutive strobe cycles.
  - 6 EOP_CONFLICT: master, EOP_N=0 while any of AEN=1, ADSTB=1, IOR_N=0 or IOW_N=0.
  - 7 DACK_ILLEGAL: more than one DACK bit set, or any DACK bit set while HLDA=0.
- Capture:
  - first_err_id/first_err_ts load only while first_err_vld=0.
  - Several rules violated in one cycle: capture the lowest id; the sticky bits take all of them.
  - err_cnt adds 1 per violating cycle, not per rule, and saturates at all-ones.
- Transfers: in M_XFER, a rising IOR_N or IOW_N with exactly one DACK[i] set increments xfer_cnt[i], saturating.
- Timestamp: free-running and wraps at 2^TS_W.
- clr in the same cycle as a violation: the clear applies first, then the new violation is recorded, so sticky, count=1 and capture all reflect it.
- RESET asserted mid-transfer: immediate return to the reset state. After RESET is released, the first master rule check happens only after a fresh HLDA rise.

Decomposition:
- Package dma_mon_pkg holds:
  - FSM enum m_state_t {M_IDLE, M_REQ, M_ACK1, M_XFER};
  - rule-index localparams RULE_HLDA_TIMEOUT .. RULE_DACK_ILLEGAL;
  - NUM_RULES = 8.
- One sub-module, dma_mon_capture: sticky register, saturating err_cnt, priority encoder and first-error capture.

Test Plan:
- Legal master cycle. Stimulus: CS_N=1, HRQ=1; HLDA rises at cycle 3; AEN=1 and ADSTB=1 pulse at cycle 4; IOR_N low cycle 5; IOW_N low cycle 6; DACK=4'b0010. Response: err_sticky=0, xfer_cnt[1]=2, irq=0.
- HLDA timeout. Stimulus: HRQ=1 and HLDA=0 for 20 cycles with HLDA_TIMEOUT=16. Response: err_pulse[0] exactly once, first_err_id=0, err_cnt=1.
- Simultaneous violations. Stimulus: ADSTB held high 2 cycles, and in the second cycle IOR_N=IOW_N=0. Response: err_pulse=8'b0001_1000, first_err_id=3, err_cnt=1.
- Wait states. Stimulus: IOR_N low with READY=0 for 8 cycles -> no error; repeat with 9 cycles. Response: err_pulse[5] at edge 10 of the second case.
- Slave mode and DACK. Stimulus: CS_N=0 with ADSTB held high 3 cycles -> no error; CS_N=0 with IOR_N=IOW_N=0 -> rule 4; DACK=4'b0011 with HLDA=0 -> rule 7.
- Clear and reset. Stimulus: clr together with an EOP_N=0, AEN=1 violation -> err_sticky=8'h40, err_cnt=1. Then RESET pulse mid-M_XFER -> all outputs 0, FSM in M_IDLE.
